// File: rtl/shift_unit_if.sv
// Request/response bundle for the shift unit: operand, amount and function in,
// registered result and its valid flag out.
interface shift_unit_if #(
    parameter int N = 32
);
    localparam int K = $clog2(N);

    logic         in_valid;
    logic [N-1:0] a;
    logic [K-1:0] b;
    logic [1:0]   sf;
    logic [N-1:0] sures;
    logic         out_valid;

    modport master (
        output in_valid, a, b, sf,
        input  sures, out_valid
    );

    modport slave (
        input  in_valid, a, b, sf,
        output sures, out_valid
    );
endinterface

// File: rtl/shift_unit.sv
// Registered N-bit barrel shifter/rotator (SLL, SRL, ROTR, SRA) with one
// cycle of latency; left shifts reuse the right shifter via bit reversal.
module shift_stage #(
    parameter int N  = 32,
    parameter int SH = 1
) (
    input  logic [N-1:0] i_x,
    input  logic         i_en,
    input  logic         i_rot,
    input  logic         i_fill,
    output logic [N-1:0] o_y
);
    logic [SH-1:0] w_top;

    // Rotate re-inserts the bits falling off the bottom; otherwise replicate the fill bit.
    assign w_top = i_rot ? i_x[SH-1:0] : {SH{i_fill}};
    assign o_y   = i_en ? {w_top, i_x[N-1:SH]} : i_x;
endmodule

module shift_unit #(
    parameter  int N = 32,
    localparam int K = $clog2(N)
) (
    input  logic        clk,
    input  logic        rst_n,
    shift_unit_if.slave bus
);
    logic         w_left;
    logic         w_rot;
    logic         w_fill;
    logic [N-1:0] w_a_rev;
    logic [N-1:0] w_res_rev;
    logic [N-1:0] w_res;
    logic [N-1:0] w_stg [K+1];
    logic [N-1:0] r_sures;
    logic         r_vld;

    assign w_left = (bus.sf == 2'b00);
    assign w_rot  = (bus.sf == 2'b10);
    assign w_fill = (bus.sf == 2'b11) & bus.a[N-1];

    always_comb begin
        w_a_rev   = '0;
        w_res_rev = '0;
        for (int j = 0; j < N; j++) begin
            w_a_rev[j]   = bus.a[N-1-j];
            w_res_rev[j] = w_stg[K][N-1-j];
        end
    end

    assign w_stg[0] = w_left ? w_a_rev : bus.a;

    for (genvar i = 0; i < K; i++) begin : g_stage
        shift_stage #(
            .N  (N),
            .SH (1 << i)
        ) u_stage (
            .i_x    (w_stg[i]),
            .i_en   (bus.b[i]),
            .i_rot  (w_rot),
            .i_fill (w_fill),
            .o_y    (w_stg[i+1])
        );
    end

    assign w_res = w_left ? w_res_rev : w_stg[K];

    // Data register follows res even when idle; only the valid flag carries meaning.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sures <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_sures <= w_res;
            r_vld   <= bus.in_valid;
        end
    end

    assign bus.sures     = r_sures;
    assign bus.out_valid = r_vld;
endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit: expected results are queued with their due
// cycle when driven and compared when the unit presents them.
module tb_shift_unit;
    localparam int N = 32;

    typedef struct {
        logic [N-1:0] data;
        int           due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vec;
    int   n_err;
    exp_t q[$];

    shift_unit_if #(.N(N)) bus ();

    shift_unit #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] model(input logic [N-1:0] a, input int b, input logic [1:0] sf);
        logic [2*N-1:0] w;
        case (sf)
            2'b00:   return a << b;
            2'b01:   return a >> b;
            2'b10: begin
                w = {a, a} >> b;
                return w[N-1:0];
            end
            default: return $signed(a) >>> b;
        endcase
    endfunction

    // Drive one operation on the falling edge; optionally queue its expected result.
    task automatic issue(input logic [N-1:0] a, input int b, input logic [1:0] sf, input bit vld);
        exp_t e;
        @(negedge clk);
        bus.in_valid = vld;
        bus.a        = a;
        bus.b        = b[4:0];
        bus.sf       = sf;
        if (vld && rst_n) begin
            e.data = model(a, b, sf);
            e.due  = cyc + 1;
            q.push_back(e);
        end
    endtask

    always @(posedge clk) begin
        logic exp_v;
        exp_t e;
        cyc++;
        #2;
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        exp_v = (q.size() > 0 && q[0].due == cyc);
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_v});
        if (exp_v) begin
            e = q.pop_front();
            chk("sures", bus.sures, e.data);
        end
    end

    initial begin
        logic [1:0] sf;
        cyc          = 0;
        n_vec        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = 32'hDEADBEEF;
        bus.b        = 5'd3;
        bus.sf       = 2'b00;

        @(posedge clk);
        #3;
        chk("rst_sures", bus.sures, '0);
        chk("rst_vld", {31'b0, bus.out_valid}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;

        // Directed vectors
        for (int s = 0; s < 4; s++) begin
            sf = s[1:0];
            issue(32'h01010101, 7, sf, 1'b1);
        end
        for (int s = 0; s < 4; s++) begin
            sf = s[1:0];
            issue(32'h80000000, 31, sf, 1'b1);
        end
        for (int s = 0; s < 4; s++) begin
            sf = s[1:0];
            issue(32'h80000000, 0, sf, 1'b1);
            issue(32'h12345678, 0, sf, 1'b1);
        end
        issue(32'hF0F0F0F0, 31, 2'b11, 1'b1);
        issue(32'h7FFFFFFF, 31, 2'b11, 1'b1);
        issue(32'hC0000001, 31, 2'b10, 1'b1);
        issue(32'hAAAA5555, 16, 2'b10, 1'b1);
        issue(32'h0, 0, 2'b00, 1'b0);
        issue(32'h0, 0, 2'b00, 1'b0);

        // Back-to-back random traffic with occasional bubbles
        for (int i = 0; i < 60; i++) begin
            issue($urandom, $urandom_range(0, 31), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 5) != 0));
        end

        // Reset for one edge mid-stream, with an op presented at that edge
        issue(32'h11223344, 4, 2'b01, 1'b1);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = 32'hFFFFFFFF;
        bus.b        = 5'd1;
        bus.sf       = 2'b00;
        @(posedge clk);
        #3;
        chk("midrst_sures", bus.sures, '0);
        chk("midrst_vld", {31'b0, bus.out_valid}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        issue(32'h80000001, 1, 2'b10, 1'b1);
        issue(32'h80000001, 1, 2'b11, 1'b1);
        issue(32'h0, 0, 2'b00, 1'b0);

        repeat (4) @(negedge clk);
        chk("drain", q.size(), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
